xor_result_skid_reg: RTL

Registered pipeline stage directly downstream of the bitwise XOR bus gate in the prototype processor datapath. It captures the XOR result with a valid/ready handshake, computes zero/parity/one-hot flags at capture time, and buffers up to two entries (main plus skid) so the upstream stage never sees a combinational ready path. It also keeps a wrapping count of completed output transfers for the trace/debug panel.

---
 rtl/xor_result_skid_reg_pkg.sv | 29 ++
 rtl/xor_flag_calc.sv | 35 +++
 rtl/xor_result_skid_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/xor_result_skid_reg_pkg.sv
// ----------------------------------------------------------------------------
// xor_result_skid_reg_pkg
//
// Shared definitions for the registered stage behind the XOR bus gate.
// Sibling datapath stages import this package so that they all use the
// same state encoding and the same layout for a stored entry.
//
// Contents:
//   state_t    - occupancy state of the two-entry stage (EMPTY/ONE/FULL)
//   *_BIT      - bit positions of the flags inside a stored entry; the data
//                field sits directly above the flags
//   FLAG_W     - number of flag bits stored with every entry
// ----------------------------------------------------------------------------
package xor_result_skid_reg_pkg;

    // Occupancy of the stage: how many of main/skid hold a live entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Stored entry layout: {data, zero, parity, onehot}
    localparam int ONEHOT_BIT = 0;
    localparam int PARITY_BIT = 1;
    localparam int ZERO_BIT   = 2;
    localparam int FLAG_W     = 3;

endpackage

// File: rtl/xor_flag_calc.sv
// ----------------------------------------------------------------------------
// xor_flag_calc
//
// Combinational flag generator for an XOR result word.
//
// Parameters:
//   NrOfBits - data width (1..32)
//
// Ports:
//   Data   in  NrOfBits  word to classify
//   Zero   out 1         all bits clear
//   Parity out 1         odd number of set bits
//   OneHot out 1         exactly one bit set
// ----------------------------------------------------------------------------
module xor_flag_calc #(
    parameter int NrOfBits = 8
) (
    input  logic [NrOfBits-1:0] Data,
    output logic                Zero,
    output logic                Parity,
    output logic                OneHot
);

    // Clearing the lowest set bit leaves zero exactly when at most one bit
    // was set; combined with a non-zero word this gives one-hot. For a
    // single-bit word this collapses to OneHot = bit.
    logic [NrOfBits-1:0] low_cleared;

    assign low_cleared = Data & (Data - NrOfBits'(1));

    assign Zero   = ~|Data;
    assign Parity = ^Data;
    assign OneHot = (|Data) & ~(|low_cleared);

endmodule

// File: rtl/xor_result_skid_reg.sv
// ----------------------------------------------------------------------------
// xor_result_skid_reg
//
// Registered valid/ready stage directly downstream of the XOR bus gate.
// Flags are computed from Data_In at acceptance and stored with the data.
// A main register plus one skid register let In_Ready depend on state only,
// so the upstream stage never sees a combinational path from Out_Ready.
// A wrapping counter tracks completed output transfers for the debug panel.
//
// Parameters:
//   NrOfBits  - data width (1..32)
//   CountBits - width of Xfer_Count
//
// Ports:
//   Clock        in   1          system clock, rising edge
//   Reset        in   1          asynchronous, active-high
//   Data_In      in   NrOfBits   XOR result from the upstream gate
//   In_Valid     in   1          upstream offers Data_In
//   In_Ready     out  1          stage can accept (state only)
//   Data_Out     out  NrOfBits   head-of-stage data
//   Zero_Flag    out  1          head data is zero
//   Parity_Flag  out  1          head data has odd parity
//   OneHot_Flag  out  1          head data has exactly one bit set
//   Out_Valid    out  1          head data and flags are valid
//   Out_Ready    in   1          downstream accepts
//   Xfer_Count   out  CountBits  output handshakes modulo 2^CountBits
// ----------------------------------------------------------------------------
module xor_result_skid_reg
    import xor_result_skid_reg_pkg::*;
#(
    parameter int NrOfBits  = 8,
    parameter int CountBits = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NrOfBits-1:0]  Data_In,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic [NrOfBits-1:0]  Data_Out,
    output logic                 Zero_Flag,
    output logic                 Parity_Flag,
    output logic                 OneHot_Flag,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [CountBits-1:0] Xfer_Count
);

    localparam int EntryW = NrOfBits + FLAG_W;

    // Reset image of an entry: zero data, so only the zero flag is set.
    localparam logic [EntryW-1:0] ResetEntry = EntryW'(1) << ZERO_BIT;

    state_t state;
    state_t state_nxt;

    logic              zero_in;
    logic              parity_in;
    logic              onehot_in;
    logic [EntryW-1:0] entry_p0;
    logic [EntryW-1:0] main_p1;
    logic [EntryW-1:0] skid_p1;

    logic in_xfer;
    logic out_xfer;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic [CountBits-1:0] count_p1;

    // ---- stage 0: classify the incoming word and pack the entry ----
    xor_flag_calc #(
        .NrOfBits (NrOfBits)
    ) u_flag_calc (
        .Data   (Data_In),
        .Zero   (zero_in),
        .Parity (parity_in),
        .OneHot (onehot_in)
    );

    always_comb begin
        entry_p0                  = '0;
        entry_p0[EntryW-1:FLAG_W] = Data_In;
        entry_p0[ZERO_BIT]        = zero_in;
        entry_p0[PARITY_BIT]      = parity_in;
        entry_p0[ONEHOT_BIT]      = onehot_in;
    end

    assign In_Ready  = (state != FULL);
    assign Out_Valid = (state != EMPTY);
    assign in_xfer   = In_Valid & In_Ready;
    assign out_xfer  = Out_Valid & Out_Ready;

    // Next state and register-load selects. Main always holds the oldest
    // entry; skid only ever holds the one behind it.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // In_Ready is low here, so only the drain can happen.
                if (out_xfer) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // ---- stage 1: state, main/skid entries and transfer counter ----
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Entries are cleared on reset so the head reads as a zero word.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            main_p1 <= ResetEntry;
            skid_p1 <= ResetEntry;
        end else begin
            if (load_main_in) begin
                main_p1 <= entry_p0;
            end else if (load_main_skid) begin
                main_p1 <= skid_p1;
            end
            if (load_skid) begin
                skid_p1 <= entry_p0;
            end
        end
    end

    // Free-running modulo counter; wraps naturally at all-ones.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_p1 <= '0;
        end else if (out_xfer) begin
            count_p1 <= count_p1 + CountBits'(1);
        end
    end

    assign Data_Out    = main_p1[EntryW-1:FLAG_W];
    assign Zero_Flag   = main_p1[ZERO_BIT];
    assign Parity_Flag = main_p1[PARITY_BIT];
    assign OneHot_Flag = main_p1[ONEHOT_BIT];
    assign Xfer_Count  = count_p1;

endmodule
